tx_byte_arbiter: RTL
====================

# tx_byte_arbiter

Round-robin arbiter that shares the single write port of the CPU→UART transmit FIFO between several byte producers (CPU store path, debug/trace sources). Grants are packet-locked, so one producer's message is never interleaved with another's. A one-entry output register absorbs FIFO-full backpressure. The block sits in the CPU clock domain, between the producers and the FIFO write side (din / wen / full).

## Interface
- NUM_REQ, 2: number of requesters, legal range 2..4.
- DATA_WIDTH, 8: byte width.
- MAX_BURST, 16: maximum bytes per grant before a forced release. Legal range 1..255.
- IDLE_TIMEOUT, 64: consecutive cycles without valid from the granted requester before a forced release. Legal range 1..255.

Ports:
- clk  in  1  single clock, CPU domain; all state changes on the rising edge.
- areset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_last  in  NUM_REQ  per-requester last-byte-of-packet flag, sampled with valid.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i's byte occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  byte accepted when valid & ready are both high.
- fifo_full  in  1  FIFO full flag.
- fifo_wen  out  1  FIFO write enable.
- fifo_din  out  DATA_WIDTH  FIFO write data.
- grant  out  NUM_REQ  one-hot current owner; all zeros when no owner.
- busy  out  1  high in BUSY state or while the output register is occupied.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner held in the grant register.
- IDLE → BUSY when any req_valid is high.
  - The winner is the first valid requester scanning from ptr, ptr+1, … (mod NUM_REQ).
  - The winner is registered into grant. Arbitration costs one cycle; req_ready is all zeros in IDLE.
- BUSY behaviour:
  - req_ready[i] = grant[i] & (~out_valid | ~fifo_full).
  - Each accepted byte loads the output register and increments burst_cnt.
- BUSY → IDLE on any of these events:
  - an accepted byte with req_last = 1;
  - an accepted byte that makes burst_cnt reach MAX_BURST;
  - idle_cnt reaching IDLE_TIMEOUT.
- Output register (out_valid, out_data):
  - fifo_wen = out_valid & ~fifo_full (combinational).
  - fifo_din = out_data.
  - out_valid clears on a write unless a new byte is accepted in the same cycle.
- Release actions:
  - ptr ← index(owner)+1 mod NUM_REQ.
  - grant, burst_cnt and idle_cnt clear.
- idle_cnt:
  - increments each BUSY cycle in which the owner's req_valid is low;
  - clears on any owner-valid cycle.
- Counters are 8 bits wide and never wrap past their limits.
- Non-owners' valid and data are ignored. Their bytes stay pending, because ready is low.
- Simultaneous events:
  - When last-acceptance and MAX_BURST coincide, there is one release.
  - A release and a new request in the same cycle: the next winner is chosen in IDLE the following cycle.
- Reset (async, areset = 0), regardless of state:
  - state = IDLE, ptr = 0, grant = 0, out_valid = 0, counters = 0.
  - Outputs: req_ready = 0, fifo_wen = 0, fifo_din = 0, busy = 0.
  - Any byte in flight is dropped.
  - Reset release is synchronous to clk.

## Timing
- Latency from first valid to first accept: 1 cycle. Valid seen in cycle N (IDLE), grant in N+1, accept in N+1 if the output register is free.
- An accept in cycle N gives fifo_wen in cycle N+1 when fifo_full = 0.
- Sustained throughput is 1 byte/cycle while fifo_full = 0.
- Each grant boundary costs one bubble (the IDLE cycle).
- fifo_full = 1 with out_valid = 1: fifo_wen = 0, req_ready = 0, out_data held stable. When full clears, the write and the next accept happen in the same cycle.
- fifo_wen is never high while fifo_full is high.

## Test plan
- Reset mid-packet: req0 sends 0x11, 0x22, then areset = 0 → all outputs 0 immediately; after release, req1 valid wins, since ptr = 0 and req0 is idle.
- Round-robin: req0 and req1 both stream 1-byte packets (last = 1) with continuous valid → FIFO receives the alternating sequence 0xA0, 0xB0, 0xA1, 0xB1…, grant toggles every 2 cycles.
- Packet lock: req0 sends 0x01, 0x02, 0x03 (last on 0x03) while req1 is valid → all three bytes are written before any req1 byte; req1 is granted the cycle after release.
- Backpressure: assert fifo_full for 5 cycles during a req0 burst → fifo_wen = 0 and fifo_din stable for those cycles; no byte lost or duplicated; ordering is preserved.
- MAX_BURST = 4: req0 streams 6 bytes without last while req1 is valid → after 4 bytes grant passes to req1, then returns to req0 for the remaining 2.
- IDLE_TIMEOUT = 8: req0 sends one byte without last, then drops valid → grant released after exactly 8 idle cycles; req1 is then served.

Source files
------------

// File: rtl/tx_byte_arbiter.sv
// Round-robin, packet-locked arbiter that feeds one FIFO write port through a one-entry output register.
// First accept comes one cycle after valid in IDLE; while FIFO is full with the register occupied, all req_ready drop.
module tx_byte_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int              IDXW      = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_BUSY   = 1'b1;
  localparam logic [7:0]      BURST_LIM = 8'(MAX_BURST);
  localparam logic [7:0]      IDLE_LIM  = 8'(IDLE_TIMEOUT);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_REQ - 1);

  logic [0:0]            state_q, state_d;
  logic [IDXW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;
  logic [7:0]            idle_cnt_q, idle_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  win_found;
  logic [IDXW-1:0]       win_idx;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [IDXW-1:0]       owner_idx;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  out_room;
  logic                  wr_fire;
  logic                  accept;
  logic                  release_evt;
  logic [7:0]            burst_inc;
  logic [7:0]            idle_inc;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester scanning upward from ptr, wrapping at NUM_REQ.
  always_comb begin : p_scan
    logic [IDXW-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDXW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    owner_idx  = '0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx  = IDXW'(i);
        owner_last = req_last[i];
        owner_data = req_bytes[i];
      end
    end
  end

  assign owner_valid = |(req_valid & grant_q);
  assign out_room    = ~out_valid_q | ~fifo_full;
  assign wr_fire     = out_valid_q & ~fifo_full;
  assign accept      = (state_q == ST_BUSY) & owner_valid & out_room;

  // Counters saturate so a misconfigured limit can never wrap them.
  assign burst_inc = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
  assign idle_inc  = (idle_cnt_q == 8'hFF) ? idle_cnt_q : idle_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    release_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_BUSY;
          grant_d = win_onehot;
        end
      end
      default: begin
        if (accept) begin
          burst_cnt_d = burst_inc;
          idle_cnt_d  = '0;
          release_evt = owner_last | (burst_inc == BURST_LIM);
        end else if (owner_valid) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d  = idle_inc;
          release_evt = (idle_inc == IDLE_LIM);
        end
        if (release_evt) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
          ptr_d       = (owner_idx == LAST_IDX) ? '0 : owner_idx + IDXW'(1);
        end
      end
    endcase
  end

  // A same-cycle write and accept keep the register full with the new byte.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = owner_data;
    end else if (wr_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign req_ready = (state_q == ST_BUSY && out_room) ? grant_q : '0;
  assign fifo_wen  = wr_fire;
  assign fifo_din  = out_data_q;
  assign grant     = grant_q;
  assign busy      = (state_q == ST_BUSY) | out_valid_q;

endmodule
